// File: rtl/tinyml_source_common_ram_stream_reader_pkg.sv
// Shared types and elaboration-time parameter checks for the RAM stream reader.
package tinyml_source_common_ram_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // The RAM read port only offers an unregistered or a registered output.
  function automatic bit latency_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

  function automatic bit fifo_depth_ok(input int depth, input int lat);
    return (depth >= lat + 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/tinyml_source_common_ram_stream_reader_if.sv
// Valid/ready stream carrying RAM words with a last-beat marker.
interface tinyml_source_common_ram_stream_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic                  m_ready;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/tinyml_source_common_ram_stream_reader_chk.sv
// Invariants of the reader's credit scheme: the return FIFO can never overflow.
module tinyml_source_common_ram_stream_reader_chk #(
  parameter int FIFO_DEPTH = 4,
  parameter int CW         = 3
) (
  input logic          clk,
  input logic          rst,
  input logic          push,
  input logic          pop,
  input logic          full,
  input logic [CW-1:0] inflight,
  input logic [CW-1:0] fifo_count
);
  localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];

  logic [CW:0] outstanding_s;
  assign outstanding_s = {1'b0, inflight} + {1'b0, fifo_count};

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
  a_credit_bound: assert property (@(posedge clk) disable iff (rst) outstanding_s <= DEPTH_C);

endmodule

// File: rtl/tinyml_source_common_sync_fifo.sv
// Synchronous FIFO with occupancy count; holds returned RAM words plus last flag.
module tinyml_source_common_sync_fifo
  import tinyml_source_common_ram_stream_reader_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C  = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  if (!fifo_depth_ok(DEPTH, 1)) begin : g_bad_depth
    $error("tinyml_source_common_sync_fifo: DEPTH must be a power of 2 and at least 3");
  end

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty     = (count_r == CNT_ZERO);
  assign full      = (count_r == DEPTH_C);
  assign pop_ok_s  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign push_ok_s = push && (!full || pop_ok_s);
  assign pop_data  = mem_r[rd_ptr_r];
  assign count     = count_r;

  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/tinyml_source_common_ram_stream_reader.sv
// Burst reader: drives the RAM read address, tracks the fixed read latency and
// repacks returned words into a valid/ready stream through a credit-counted FIFO.
module tinyml_source_common_ram_stream_reader
  import tinyml_source_common_ram_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 9,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  tinyml_source_common_ram_stream_reader_if.master m
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]           DEPTH_C   = FIFO_DEPTH[CW:0];
  localparam logic [CW-1:0]         INF_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0]         INF_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   LEN_ZERO  = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   LEN_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  if (!latency_ok(READ_LATENCY)) begin : g_bad_latency
    $error("tinyml_source_common_ram_stream_reader: READ_LATENCY must be 1 or 2");
  end
  if (!fifo_depth_ok(FIFO_DEPTH, READ_LATENCY)) begin : g_bad_depth
    $error("tinyml_source_common_ram_stream_reader: FIFO_DEPTH must be a power of 2 and >= READ_LATENCY+2");
  end

  state_e                  state_r;
  state_e                  state_next_s;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [ADDR_WIDTH:0]     remaining_r;
  logic [CW-1:0]           inflight_r;
  logic [READ_LATENCY-1:0] ret_v_r;
  logic [READ_LATENCY-1:0] ret_l_r;
  logic                    busy_r;
  logic                    done_r;

  logic                    accept_s;
  logic                    issue_s;
  logic                    last_issue_s;
  logic                    done_next_s;
  logic                    credit_ok_s;
  logic                    push_s;
  logic                    pop_s;
  logic                    last_fire_s;
  logic [DATA_WIDTH:0]     fifo_rdata_s;
  logic [CW-1:0]           fifo_count_s;
  logic                    fifo_full_s;
  logic                    fifo_empty_s;

  // Words already requested count against the FIFO as if they had landed.
  assign credit_ok_s  = ({1'b0, inflight_r} + {1'b0, fifo_count_s}) < DEPTH_C;
  assign last_issue_s = issue_s && (remaining_r == LEN_ONE);
  assign push_s       = ret_v_r[READ_LATENCY-1];
  assign pop_s        = !fifo_empty_s && m.m_ready;
  assign last_fire_s  = pop_s && fifo_rdata_s[DATA_WIDTH];

  assign m.m_valid = !fifo_empty_s;
  assign m.m_data  = fifo_empty_s ? {DATA_WIDTH{1'b0}} : fifo_rdata_s[DATA_WIDTH-1:0];
  assign m.m_last  = !fifo_empty_s && fifo_rdata_s[DATA_WIDTH];
  assign busy      = busy_r;
  assign done      = done_r;
  assign ram_addr  = addr_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    issue_s      = 1'b0;
    done_next_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (length != LEN_ZERO) begin
            accept_s     = 1'b1;
            state_next_s = ST_READ;
          end else begin
            done_next_s  = 1'b1;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (credit_ok_s) begin
          issue_s = 1'b1;
          if (remaining_r == LEN_ONE) begin
            state_next_s = ST_DRAIN;
          end else begin
            state_next_s = ST_READ;
          end
        end else begin
          state_next_s = ST_READ;
        end
      end
      ST_DRAIN: begin
        if (last_fire_s && (inflight_r == INF_ZERO)) begin
          state_next_s = ST_IDLE;
          done_next_s  = 1'b1;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      addr_r      <= ADDR_ZERO;
      remaining_r <= LEN_ZERO;
    end else begin
      busy_r <= (state_next_s != ST_IDLE);
      done_r <= done_next_s;
      if (accept_s) begin
        addr_r      <= base_addr;
        remaining_r <= length;
      end else if (issue_s) begin
        addr_r      <= addr_r + ADDR_ONE;
        remaining_r <= remaining_r - LEN_ONE;
      end
    end
  end

  // The RAM has no enable, so each issued read is tagged and followed through
  // the latency pipe; untagged RAM outputs are simply ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      ret_v_r    <= {READ_LATENCY{1'b0}};
      ret_l_r    <= {READ_LATENCY{1'b0}};
      inflight_r <= INF_ZERO;
    end else begin
      ret_v_r[0] <= issue_s;
      ret_l_r[0] <= last_issue_s;
      for (int i = 1; i < READ_LATENCY; i++) begin
        ret_v_r[i] <= ret_v_r[i-1];
        ret_l_r[i] <= ret_l_r[i-1];
      end
      case ({issue_s, push_s})
        2'b10:   inflight_r <= inflight_r + INF_ONE;
        2'b01:   inflight_r <= inflight_r - INF_ONE;
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  tinyml_source_common_sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data ({ret_l_r[READ_LATENCY-1], ram_dout}),
    .pop       (pop_s),
    .pop_data  (fifo_rdata_s),
    .count     (fifo_count_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  tinyml_source_common_ram_stream_reader_chk #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CW         (CW)
  ) u_chk (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .pop        (pop_s),
    .full       (fifo_full_s),
    .inflight   (inflight_r),
    .fifo_count (fifo_count_s)
  );

endmodule

// File: tb/tb_tinyml_source_common_ram_stream_reader.sv
// Drives a latency-1 and a latency-2 reader with identical stimulus and checks
// each stream against the burst contents expected from the RAM image.
module tb_tinyml_source_common_ram_stream_reader;
  localparam int DW    = 8;
  localparam int AW    = 9;
  localparam int DEPTH = 4;
  localparam int MEMW  = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          m_ready;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;

  wire [1:0]         busy_v;
  wire [1:0]         done_v;
  wire [1:0]         valid_v;
  wire [1:0]         last_v;
  wire [1:0][AW-1:0] addr_v;
  wire [1:0][DW-1:0] data_v;
  wire [1:0][DW-1:0] dout_v;

  logic [DW-1:0] mem [MEMW];
  logic [DW-1:0] q0;
  logic [DW-1:0] q1a;
  logic [DW-1:0] q1b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tinyml_source_common_ram_stream_reader_if #(.DATA_WIDTH(DW)) s0 ();
  tinyml_source_common_ram_stream_reader_if #(.DATA_WIDTH(DW)) s1 ();

  assign s0.m_ready = m_ready;
  assign s1.m_ready = m_ready;
  assign valid_v    = {s1.m_valid, s0.m_valid};
  assign last_v     = {s1.m_last, s0.m_last};
  assign data_v[0]  = s0.m_data;
  assign data_v[1]  = s1.m_data;

  tinyml_source_common_ram_stream_reader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .FIFO_DEPTH(DEPTH)
  ) dut0 (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy_v[0]), .done(done_v[0]), .ram_addr(addr_v[0]), .ram_dout(dout_v[0]), .m(s0)
  );

  tinyml_source_common_ram_stream_reader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .FIFO_DEPTH(DEPTH)
  ) dut1 (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy_v[1]), .done(done_v[1]), .ram_addr(addr_v[1]), .ram_dout(dout_v[1]), .m(s1)
  );

  // RAM read ports: one output stage for dut0, two for dut1.
  always @(posedge clk) begin
    q0  <= mem[addr_v[0]];
    q1a <= mem[addr_v[1]];
    q1b <= q1a;
  end
  assign dout_v[0] = q0;
  assign dout_v[1] = q1b;

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; m_ready = 1'b0; base_addr = 9'd0; length = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (busy_v[d] !== 1'b0 || done_v[d] !== 1'b0 || addr_v[d] !== 9'd0 ||
          valid_v[d] !== 1'b0 || data_v[d] !== 8'd0 || last_v[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset dut%0d: busy=%b done=%b addr=%0d valid=%b data=%0d last=%b, required all 0",
                 d, busy_v[d], done_v[d], addr_v[d], valid_v[d], data_v[d], last_v[d]);
      end
    end
    rst = 1'b0;
  endtask

  // mode 0: m_ready high, 1: three cycles low then one high, 2: random.
  task automatic run_burst(input int b, input int len, input int mode, input bit inject);
    logic [DW-1:0] exp_d [$];
    int idx [2];
    int last_hs [2];
    int first_v [2];
    int done_c [2];
    bit hold [2];
    logic [DW-1:0] pdata [2];
    logic plast [2];
    int budget;
    int issued;
    int lat;
    bit exp_done;
    for (int k = 0; k < len; k++) exp_d.push_back(mem[(b + k) % MEMW]);
    for (int d = 0; d < 2; d++) begin
      idx[d] = 0; last_hs[d] = -10; first_v[d] = -1; done_c[d] = -1;
      hold[d] = 1'b0; pdata[d] = 8'd0; plast[d] = 1'b0;
    end
    budget = 100 + 8 * len;
    @(posedge clk); #1;
    start = 1'b1; base_addr = b[AW-1:0]; length = len[AW:0];
    m_ready = (mode == 0) || ((mode == 2) && ($urandom_range(0, 1) == 1));
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      start = inject && (c == 2);
      if (inject && c == 2) begin
        base_addr = base_addr + 9'd100;
        length    = 10'd3;
      end
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ((c % 4) == 3);
        default: m_ready = ($urandom_range(0, 1) == 1);
      endcase
      for (int d = 0; d < 2; d++) begin
        lat = d + 1;
        if (done_c[d] < 0) begin
          exp_done = (idx[d] == len) && (c == last_hs[d] + 1);
          checks++;
          if (done_v[d] !== exp_done) begin
            errors++;
            $display("FAIL done dut%0d cycle %0d: got %b, required %b", d, c, done_v[d], exp_done);
          end
          checks++;
          if (busy_v[d] !== !exp_done) begin
            errors++;
            $display("FAIL busy dut%0d cycle %0d: got %b, required %b", d, c, busy_v[d], !exp_done);
          end
          issued = (int'(addr_v[d]) - b + MEMW) % MEMW;
          checks++;
          if (issued < idx[d] || issued - idx[d] > DEPTH) begin
            errors++;
            $display("FAIL credit dut%0d cycle %0d: issued=%0d accepted=%0d, outstanding must be 0..%0d",
                     d, c, issued, idx[d], DEPTH);
          end
          if (mode == 0 && c <= len) begin
            checks++;
            if (addr_v[d] !== 9'((b + c - 1) % MEMW)) begin
              errors++;
              $display("FAIL ram_addr dut%0d cycle %0d: got %0d, required %0d",
                       d, c, addr_v[d], (b + c - 1) % MEMW);
            end
          end
          if (exp_done) begin
            done_c[d] = c;
            if (mode == 0) begin
              checks++;
              if (first_v[d] != 2 + lat || c != 2 + lat + len) begin
                errors++;
                $display("FAIL timing dut%0d: first valid cycle %0d done cycle %0d, required %0d and %0d",
                         d, first_v[d], c, 2 + lat, 2 + lat + len);
              end
            end
          end
        end else if (c <= done_c[d] + 2) begin
          checks++;
          if (done_v[d] !== 1'b0 || busy_v[d] !== 1'b0 || valid_v[d] !== 1'b0) begin
            errors++;
            $display("FAIL after_done dut%0d cycle %0d: done=%b busy=%b valid=%b, required 0 0 0",
                     d, c, done_v[d], busy_v[d], valid_v[d]);
          end
        end
        if (hold[d]) begin
          checks++;
          if (valid_v[d] !== 1'b1 || data_v[d] !== pdata[d] || last_v[d] !== plast[d]) begin
            errors++;
            $display("FAIL hold dut%0d cycle %0d: valid=%b data=%0d last=%b, required 1 %0d %b",
                     d, c, valid_v[d], data_v[d], last_v[d], pdata[d], plast[d]);
          end
        end
        if (valid_v[d] === 1'b1) begin
          if (idx[d] >= len) begin
            checks++;
            errors++;
            $display("FAIL extra_valid dut%0d cycle %0d: data=%0d after all %0d words", d, c, data_v[d], len);
          end else begin
            if (first_v[d] < 0) first_v[d] = c;
            if (m_ready) begin
              checks++;
              if (data_v[d] !== exp_d[idx[d]] || last_v[d] !== (idx[d] == len - 1)) begin
                errors++;
                $display("FAIL beat dut%0d word %0d: data=%0d last=%b, required %0d %b",
                         d, idx[d], data_v[d], last_v[d], exp_d[idx[d]], (idx[d] == len - 1));
              end
              last_hs[d] = c;
              idx[d]++;
            end
          end
        end
        hold[d]  = (valid_v[d] === 1'b1) && !m_ready;
        pdata[d] = data_v[d];
        plast[d] = last_v[d];
      end
      if (done_c[0] >= 0 && done_c[1] >= 0 && c >= done_c[0] + 2 && c >= done_c[1] + 2) break;
    end
    start = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (done_c[d] < 0 || idx[d] != len) begin
        errors++;
        $display("FAIL completion dut%0d: words=%0d done_cycle=%0d, required %0d words and a done pulse",
                 d, idx[d], done_c[d], len);
      end
    end
  endtask

  task automatic test_basic();          run_burst(10, 4, 0, 1'b0);  endtask
  task automatic test_wrap();           run_burst(510, 4, 0, 1'b0); endtask
  task automatic test_backpressure();   run_burst(20, 16, 1, 1'b0); endtask
  task automatic test_latency2();       run_burst(0, 3, 0, 1'b0);   endtask
  task automatic test_start_while_busy(); run_burst(200, 6, 0, 1'b1); endtask

  task automatic test_zero_length();
    @(posedge clk); #1;
    start = 1'b1; base_addr = 9'd77; length = 10'd0; m_ready = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (done_v[d] !== (c == 1) || busy_v[d] !== 1'b0 || valid_v[d] !== 1'b0) begin
          errors++;
          $display("FAIL zero_length dut%0d cycle %0d: done=%b busy=%b valid=%b, required %b 0 0",
                   d, c, done_v[d], busy_v[d], valid_v[d], (c == 1));
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    @(posedge clk); #1;
    start = 1'b1; base_addr = 9'd37; length = 10'd8; m_ready = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 5) rst = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (busy_v[d] !== 1'b0 || done_v[d] !== 1'b0 || addr_v[d] !== 9'd0 ||
          valid_v[d] !== 1'b0 || data_v[d] !== 8'd0 || last_v[d] !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset dut%0d: busy=%b done=%b addr=%0d valid=%b data=%0d last=%b, required all 0",
                 d, busy_v[d], done_v[d], addr_v[d], valid_v[d], data_v[d], last_v[d]);
      end
    end
    for (int c = 7; c <= 14; c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (done_v[d] !== 1'b0 || valid_v[d] !== 1'b0 || busy_v[d] !== 1'b0) begin
          errors++;
          $display("FAIL post_reset_idle dut%0d cycle %0d: done=%b valid=%b busy=%b, required 0 0 0",
                   d, c, done_v[d], valid_v[d], busy_v[d]);
        end
      end
    end
    run_burst(0, 2, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < MEMW; i++) mem[i] = 8'($urandom_range(0, 255));
      run_burst($urandom_range(0, MEMW - 1), $urandom_range(1, 40), 2, 1'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < MEMW; i++) mem[i] = 8'(i);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_length();
    test_latency2();
    test_start_while_busy();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tinyml_source_common_ram_stream_reader.md
# tinyml_source_common_ram_stream_reader

Burst reader that sits directly downstream of the common true-dual-port RAM read port. It drives the RAM address, tracks the RAM's fixed read latency (1 or 2 cycles, matching the RAM's output-register setting), and turns the returned words into a valid/ready stream with last-beat marking. It is used to stream line buffers and feature-map tiles into the next accelerator stage. A small credit-counted FIFO absorbs downstream backpressure, because the RAM read port has no enable or stall.

## Interface
- DATA_WIDTH, 8: RAM word and stream data width.
- ADDR_WIDTH, 9: RAM address width. Burst length is ADDR_WIDTH+1 bits, so a full-memory burst is possible.
- READ_LATENCY, 1: RAM read latency in cycles. Only 1 or 2 are legal; any other value is an elaboration error.
- FIFO_DEPTH, 4: return-buffer depth. Must be a power of 2 and ≥ READ_LATENCY+2.

Ports:
- clk  in  1  single clock for the whole block and the RAM port it drives.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request. Ignored while busy.
- base_addr  in  ADDR_WIDTH  first word address, sampled with start.
- length  in  ADDR_WIDTH+1  number of words, sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the burst has completed.
- ram_addr  out  ADDR_WIDTH  address to the RAM read port, driven directly from a register.
- ram_dout  in  DATA_WIDTH  RAM read data.
- m_valid  out  1  stream data valid.
- m_data  out  DATA_WIDTH  stream data.
- m_last  out  1  marks the final word of the burst.
- m_ready  in  1  downstream accept.

## Operation
- Reset values: busy=0, done=0, ram_addr=0, m_valid=0, m_data=0, m_last=0. FIFO is empty, in-flight counter is 0, state is IDLE.
- IDLE state:
  - start with length≠0: latch base_addr and length, go to READ.
  - start with length=0: pulse done the next cycle, do not assert busy, stay in IDLE.
- READ state:
  - A read issues in a cycle when inflight + fifo_count < FIFO_DEPTH.
  - On issue: ram_addr increments modulo 2^ADDR_WIDTH (511 wraps to 0), and the remaining count decrements.
  - The issue of the final word moves the state to DRAIN.
- Return tracking: a READ_LATENCY-deep valid shift register marks which RAM outputs belong to issued reads. Each marked word is written to the FIFO together with its last flag.
- DRAIN state: when inflight=0, the FIFO is empty and the last beat has been accepted, pulse done, drop busy and return to IDLE.
- Credit rule: the FIFO never overflows. If an overflow occurs anyway, that is an assertion failure.
- Simultaneous FIFO push and pop: fifo_count is unchanged.
- start while busy: ignored. The latched parameters are not modified.
- rst mid-burst: all in-flight data is discarded, and outputs return to their reset values on the next cycle. No done pulse is generated.

## Timing
- Cycle 0: start accepted. Cycle 1: busy=1, ram_addr=base, first read issued.
- First m_valid appears in cycle 2+READ_LATENCY, i.e. cycle 3 when READ_LATENCY=1.
- Throughput with m_ready held high: 1 word per cycle, with no bubbles.
- After m_ready deasserts, at most FIFO_DEPTH words are outstanding. Issue resumes the cycle after credit frees.
- Stream hold rule: while m_valid=1 and m_ready=0, m_data and m_last stay stable.
- done pulses the cycle after the last beat handshake, and busy falls in that same cycle.
- A new start is accepted in the cycle done is high.

## Structure
- A shared package holds the state encoding (IDLE, READ, DRAIN) and the legal-READ_LATENCY check function.
- One sub-module: tinyml_source_common_sync_fifo. It is a DATA_WIDTH+1 wide (data plus last), FIFO_DEPTH deep synchronous FIFO that reports count, full and empty, and resets on rst.
- The top level holds the FSM, address and remaining counters, the in-flight counter and the latency shift register.

## Test plan
- Basic burst: base=10, length=4, READ_LATENCY=1, m_ready=1, RAM preloaded with mem[i]=i. Required: m_data 10,11,12,13 in cycles 3–6; m_last only in cycle 6; done in cycle 7.
- Wrap-around: ADDR_WIDTH=9, base=510, length=4. Required: ram_addr sequence 510,511,0,1, and the data sequence matches.
- Backpressure: length=16, m_ready toggling with a 3-cycle-low / 1-cycle-high pattern. Required: all 16 words in order, no loss or duplicates, and inflight+fifo_count never exceeds 4.
- Zero length: start with length=0. Required: done in cycle 1, busy stays 0, m_valid is never asserted.
- Latency 2: READ_LATENCY=2, base=0, length=3. Required: first m_valid in cycle 4, data mem[0..2], then done.
- Reset mid-burst: length=8, rst asserted in cycle 5. Required: all outputs at reset values in cycle 6, no done pulse, and the next start with base=0, length=2 streams cleanly.
